// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator with a valid/ready
// handshake, a two-entry (main + skid) result buffer, a sideband tag and a
// saturating counter of accepted illegal-opcode instructions.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // A buffered entry holds only the decoded result: {tag, illegal, fmt, imm}
    localparam int ENT_W = TAG_W + 1 + 3 + XLEN;

    logic [XLEN-1:0]  decImm;
    logic [2:0]       decFmt;
    logic             decIllegal;
    logic [5:0]       decShamt;
    logic [ENT_W-1:0] decEntry;

    logic             mainValid_q, mainValid_d;
    logic             skidValid_q, skidValid_d;
    logic [ENT_W-1:0] main_q, main_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic drain;

    // RV64 shift amounts are six bits wide, RV32 ones five; upper funct bits are ignored
    assign decShamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

    // Purely combinational decode of the incoming instruction word
    always_comb begin
        decImm     = '0;
        decFmt     = FMT_NONE;
        decIllegal = 1'b0;
        case (in_instr[6:0])
            OP_IMM: begin
                if (in_instr[13:12] == 2'b01) begin
                    decFmt = FMT_SHAMT;
                    decImm = XLEN'(decShamt);
                end else begin
                    decFmt = FMT_I;
                    decImm = XLEN'($signed(in_instr[31:20]));
                end
            end
            OP_LOAD, OP_JALR: begin
                decFmt = FMT_I;
                decImm = XLEN'($signed(in_instr[31:20]));
            end
            OP_STORE: begin
                decFmt = FMT_S;
                decImm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OP_BRANCH: begin
                decFmt = FMT_B;
                decImm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                        in_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                decFmt = FMT_U;
                decImm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                decFmt = FMT_J;
                decImm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                        in_instr[30:21], 1'b0}));
            end
            OP_REG: begin
                decFmt = FMT_NONE;
            end
            default: begin
                decIllegal = 1'b1;
            end
        endcase
    end

    assign decEntry = {in_tag, decIllegal, decFmt, decImm};

    // in_ready depends only on a flop, so out_ready never reaches it combinationally
    assign in_ready = ~skidValid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = mainValid_q & out_ready;

    // Buffer next state: main always holds the oldest result, skid the younger one
    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        main_d      = main_q;
        skid_d      = skid_q;
        if (drain) begin
            if (skidValid_q) begin
                main_d      = skid_q;
                skidValid_d = 1'b0;
            end else if (accept) begin
                main_d = decEntry;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (accept) begin
            if (mainValid_q) begin
                skid_d      = decEntry;
                skidValid_d = 1'b1;
            end else begin
                main_d      = decEntry;
                mainValid_d = 1'b1;
            end
        end
    end

    // Illegal counter advances on acceptance only and sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (accept && decIllegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops every buffered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = mainValid_q;
    assign out_imm     = main_q[XLEN-1:0];
    assign out_fmt     = main_q[XLEN+2:XLEN];
    assign out_illegal = main_q[XLEN+3];
    assign out_tag     = main_q[ENT_W-1:XLEN+4];
    assign illegal_cnt = cnt_q;

endmodule
